// File: rtl/mem_pkg.sv
// Shared definitions for the code/SRAM memory controller.
//   size_e        : d_size encodings (byte / half / word / reserved)
//   port_state_e  : per-port handshake FSM states
//   lane_mask()   : little-endian byte-lane enables from access size and byte offset
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } port_state_e;

  // Byte lanes touched by an access of the given size at byte offset off.
  // Reserved size touches no lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size_e'(size))
      SIZE_BYTE: m = 4'b0001 << off;
      SIZE_HALF: m = 4'b0011 << off;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// Request/ready handshake for one memory port: IDLE -> WAIT -> RESP -> IDLE.
//   clk, rst     : clock, asynchronous active-high reset
//   req          : request, held until ready
//   fault_in     : fault evaluated on the live request fields
//   payload_in   : request fields to capture at acceptance (PW bits)
//   ready        : registered one-cycle response pulse (high exactly in RESP)
//   fault_lat    : fault captured at acceptance
//   payload_lat  : request fields captured at acceptance
// A faulting request skips the wait states and answers on the next cycle.
module mem_port_fsm
  import mem_pkg::*;
#(
  parameter int unsigned WAIT = 0,
  parameter int unsigned PW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          fault_in,
  input  logic [PW-1:0] payload_in,
  output logic          ready,
  output logic          fault_lat,
  output logic [PW-1:0] payload_lat
);

  port_state_e state;
  logic [3:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ready       <= 1'b0;
      fault_lat   <= 1'b0;
      payload_lat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready <= 1'b0;
          if (req) begin
            payload_lat <= payload_in;
            fault_lat   <= fault_in;
            if (fault_in || WAIT == 0) begin
              state <= ST_RESP;
              ready <= 1'b1;
            end else begin
              cnt   <= 4'(WAIT - 1);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          ready <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/code_sram_mem_ctrl.sv
// Cortex-M0 memory: code ROM at 0 and data SRAM at SRAM_BASE, with an
// instruction-fetch port (word only, code region) and a load/store port
// (byte/half/word, both regions, stores to SRAM only).
//   clk, rst                          : clock, asynchronous active-high reset
//   i_req, i_addr                     : fetch request / byte address
//   i_ready, i_rdata, i_fault         : fetch response pulse, word, fault
//   d_req, d_we, d_size, d_addr,
//   d_wdata                           : data request (right-aligned store data)
//   d_ready, d_rdata, d_fault         : data response pulse, right-aligned
//                                       zero-extended load data, fault
// Responses are zero outside the ready cycle; faulted accesses return 0.
module code_sram_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned CODE_BYTES = 4096,
  parameter logic [31:0] SRAM_BASE  = 32'h2000_0000,
  parameter int unsigned SRAM_BYTES = 4096,
  parameter int unsigned WAIT_I     = 0,
  parameter int unsigned WAIT_D     = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_fault
);

  localparam int unsigned CODE_AW    = $clog2(CODE_BYTES);
  localparam int unsigned SRAM_AW    = $clog2(SRAM_BYTES);
  localparam int unsigned ADDR_AW    = (CODE_AW > SRAM_AW) ? CODE_AW : SRAM_AW;
  localparam int unsigned CODE_WORDS = CODE_BYTES / 4;
  localparam int unsigned SRAM_WORDS = SRAM_BYTES / 4;

  logic [31:0] code_mem [CODE_WORDS];
  logic [31:0] sram_mem [SRAM_WORDS];

  initial begin
    for (int unsigned w = 0; w < CODE_WORDS; w++) code_mem[w] = '0;
  end

  // ---------------- I port ----------------
  logic                 i_fault_now;
  logic                 i_fault_lat;
  logic [CODE_AW-3:0]   i_idx_lat;

  assign i_fault_now = (i_addr[1:0] != 2'b00) || (i_addr >= 32'(CODE_BYTES));

  mem_port_fsm #(.WAIT(WAIT_I), .PW(CODE_AW - 2)) u_i_fsm (
    .clk         (clk),
    .rst         (rst),
    .req         (i_req),
    .fault_in    (i_fault_now),
    .payload_in  (i_addr[CODE_AW-1:2]),
    .ready       (i_ready),
    .fault_lat   (i_fault_lat),
    .payload_lat (i_idx_lat)
  );

  assign i_rdata = (i_ready && !i_fault_lat) ? code_mem[i_idx_lat] : '0;
  assign i_fault = i_ready && i_fault_lat;

  // ---------------- D port ----------------
  // Only the in-region offset bits are captured; the region choice is
  // resolved at acceptance so the full address need not be held.
  typedef struct packed {
    logic               we;
    logic [1:0]         size;
    logic               in_code;
    logic [ADDR_AW-1:0] addr;
    logic [31:0]        wdata;
  } d_req_t;

  d_req_t      d_in, d_lat;
  logic        d_in_code, d_in_sram, d_misalign, d_fault_now, d_fault_lat;
  logic [31:0] d_sram_off;

  assign d_sram_off = d_addr - SRAM_BASE;
  assign d_in_code  = d_addr < 32'(CODE_BYTES);
  assign d_in_sram  = d_sram_off < 32'(SRAM_BYTES);
  assign d_misalign = (d_size == SIZE_HALF && d_addr[0]) ||
                      (d_size == SIZE_WORD && d_addr[1:0] != 2'b00);
  assign d_fault_now = d_misalign || (d_size == SIZE_RSVD) ||
                       !(d_in_code || d_in_sram) || (d_we && d_in_code);

  always_comb begin
    d_in         = '0;
    d_in.we      = d_we;
    d_in.size    = d_size;
    d_in.in_code = d_in_code;
    d_in.addr    = d_addr[ADDR_AW-1:0];
    d_in.wdata   = d_wdata;
  end

  mem_port_fsm #(.WAIT(WAIT_D), .PW($bits(d_req_t))) u_d_fsm (
    .clk         (clk),
    .rst         (rst),
    .req         (d_req),
    .fault_in    (d_fault_now),
    .payload_in  (d_in),
    .ready       (d_ready),
    .fault_lat   (d_fault_lat),
    .payload_lat (d_lat)
  );

  logic [SRAM_AW-3:0] d_sidx;
  logic [1:0]         d_off;
  logic [31:0]        d_word, d_shift, d_keep, d_wshift;
  logic [3:0]         d_size_lanes, d_wmask;

  assign d_sidx       = d_lat.addr[SRAM_AW-1:2];
  assign d_off        = d_lat.addr[1:0];
  assign d_word       = d_lat.in_code ? code_mem[d_lat.addr[CODE_AW-1:2]] : sram_mem[d_sidx];
  assign d_shift      = d_word >> {d_off, 3'b000};
  assign d_size_lanes = lane_mask(d_lat.size, 2'b00);
  assign d_keep       = {{8{d_size_lanes[3]}}, {8{d_size_lanes[2]}},
                         {8{d_size_lanes[1]}}, {8{d_size_lanes[0]}}};
  assign d_wmask      = lane_mask(d_lat.size, d_off);
  assign d_wshift     = d_lat.wdata << {d_off, 3'b000};

  assign d_rdata = (d_ready && !d_fault_lat && !d_lat.we) ? (d_shift & d_keep) : '0;
  assign d_fault = d_ready && d_fault_lat;

  // Store commits on the edge that ends RESP; rst at that edge drops it.
  always_ff @(posedge clk) begin
    if (!rst && d_ready && !d_fault_lat && d_lat.we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (d_wmask[b]) sram_mem[d_sidx][8*b +: 8] <= d_wshift[8*b +: 8];
      end
    end
  end

endmodule
